// File: rtl/uart_pkg.sv
// Shared types and default constants for the UART transmit arbiter.
// Holds the arbiter FSM state enum and default parameter values.
package uart_pkg;

  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_WIDTH     = 8;
  localparam int DEF_MAX_BURST = 16;
  localparam int DEF_TIMEOUT   = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARB   = 2'd1,
    XFER  = 2'd2,
    DRAIN = 2'd3
  } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester + UART-side signals of uart_tx_arbiter.
// slave: the arbiter; master: requesters and the UART transmitter.
interface uart_tx_arbiter_if
  import uart_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int WIDTH   = DEF_WIDTH
);

  logic [NUM_REQ-1:0]       req_tvalid_i;
  logic [NUM_REQ*WIDTH-1:0] req_tdata_i;
  logic [NUM_REQ-1:0]       req_tlast_i;
  logic [NUM_REQ-1:0]       req_tready_o;
  logic [WIDTH-1:0]         tx_data_o;
  logic                     tx_valid_o;
  logic                     tx_ready_i;
  logic [NUM_REQ-1:0]       grant_o;
  logic                     active_o;

  modport slave (
    input  req_tvalid_i,
    input  req_tdata_i,
    input  req_tlast_i,
    input  tx_ready_i,
    output req_tready_o,
    output tx_data_o,
    output tx_valid_o,
    output grant_o,
    output active_o
  );

  modport master (
    output req_tvalid_i,
    output req_tdata_i,
    output req_tlast_i,
    output tx_ready_i,
    input  req_tready_o,
    input  tx_data_o,
    input  tx_valid_o,
    input  grant_o,
    input  active_o
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first request at or after ptr_i.
// Ports: req_i, ptr_i in; one-hot grant_o, winner idx_o, valid_o out.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
  output logic [NUM_REQ-1:0]         grant_o,
  output logic [$clog2(NUM_REQ)-1:0] idx_o,
  output logic                       valid_o
);

  localparam int PW = $clog2(NUM_REQ);

  always_comb begin
    int k;
    logic [PW-1:0] kx;
    k       = 0;
    kx      = '0;
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = int'(ptr_i) + i;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      kx = PW'(k);
      if (!valid_o && req_i[kx]) begin
        valid_o      = 1'b1;
        grant_o[kx]  = 1'b1;
        idx_o        = kx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ
// requesters; bursts end on tlast or after MAX_BURST characters.
// Ports: clk_i, reset_i (async, active-high), bus (slave modport).
// Optional macro UART_TX_ARB_TIMEOUT_EN: drop a grant after TIMEOUT
// idle cycles of the owning requester.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int WIDTH     = DEF_WIDTH,
  parameter int MAX_BURST = DEF_MAX_BURST,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input logic            clk_i,
  input logic            reset_i,
  uart_tx_arbiter_if.slave bus
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST) + 1;

  if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_BURST < 1 || TIMEOUT < 1)
  begin : g_bad_cfg
    $error("uart_tx_arbiter: illegal parameter set");
  end

  arb_state_e         state_q;
  logic [PW-1:0]      rr_ptr_q;
  logic [CW-1:0]      burst_q;
  logic [NUM_REQ-1:0] grant_q;
  logic               tx_valid_q;
  logic [WIDTH-1:0]   tx_data_q;

  logic [NUM_REQ-1:0] arb_grant;
  logic [PW-1:0]      arb_idx;
  logic               arb_valid;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req_i   (bus.req_tvalid_i),
    .ptr_i   (rr_ptr_q),
    .grant_o (arb_grant),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  logic               can_load;
  logic [NUM_REQ-1:0] tready;
  logic               accept;
  logic               acc_last;
  logic               g_valid;
  logic               burst_end;
  logic [WIDTH-1:0]   acc_data;
  logic               timed_out;
  logic [PW-1:0]      next_ptr;

  // The output register can take a new char if empty or draining now.
  assign can_load  = !tx_valid_q || bus.tx_ready_i;
  assign tready    = (state_q == XFER && can_load) ? grant_q : '0;
  assign accept    = |(tready & bus.req_tvalid_i);
  assign acc_last  = |(grant_q & bus.req_tlast_i);
  assign g_valid   = |(grant_q & bus.req_tvalid_i);
  assign burst_end = acc_last || (burst_q == CW'(MAX_BURST - 1));
  assign next_ptr  = (arb_idx == PW'(NUM_REQ - 1)) ?
                     '0 : arb_idx + 1'b1;

  always_comb begin
    acc_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_q[k]) acc_data = bus.req_tdata_i[k*WIDTH +: WIDTH];
    end
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] idle_q;
  assign timed_out = (state_q == XFER) && !g_valid &&
                     (idle_q == TW'(TIMEOUT - 1));
`else
  assign timed_out = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      burst_q    <= '0;
      grant_q    <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
`ifdef UART_TX_ARB_TIMEOUT_EN
      idle_q     <= '0;
`endif
    end else begin
      // Accept and UART take in one cycle keeps tx_valid high.
      if (accept) begin
        tx_data_q  <= acc_data;
        tx_valid_q <= 1'b1;
      end else if (bus.tx_ready_i) begin
        tx_valid_q <= 1'b0;
      end

      unique case (state_q)
        IDLE: begin
          if (|bus.req_tvalid_i) state_q <= ARB;
        end
        ARB: begin
          if (arb_valid) begin
            grant_q  <= arb_grant;
            rr_ptr_q <= next_ptr;
            burst_q  <= '0;
            state_q  <= XFER;
`ifdef UART_TX_ARB_TIMEOUT_EN
            idle_q   <= '0;
`endif
          end else begin
            state_q <= IDLE;
          end
        end
        XFER: begin
          if (accept) begin
            burst_q <= burst_q + 1'b1;
`ifdef UART_TX_ARB_TIMEOUT_EN
            idle_q  <= '0;
`endif
            if (burst_end) begin
              grant_q <= '0;
              state_q <= DRAIN;
            end
          end else if (timed_out) begin
            grant_q <= '0;
            state_q <= DRAIN;
          end
`ifdef UART_TX_ARB_TIMEOUT_EN
          else if (!g_valid) begin
            idle_q <= idle_q + 1'b1;
          end
`endif
        end
        DRAIN: begin
          if (can_load) state_q <= ARB;
        end
      endcase
    end
  end

  assign bus.req_tready_o = tready;
  assign bus.tx_data_o    = tx_data_q;
  assign bus.tx_valid_o   = tx_valid_q;
  assign bus.grant_o      = grant_q;
  assign bus.active_o     = (|grant_q) || tx_valid_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: random messages per requester,
// a message-level round-robin model predicts grants and the char stream.
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MB = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(N), .WIDTH(W)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ(N), .WIDTH(W), .MAX_BURST(MB), .TIMEOUT(64)
  ) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int sq[N][$];
  int mq[N][$];
  int exp_tx[$];
  int exp_gnt[$];
  int m_ptr = 0;
  int ready_pct = 100;
  int tx_cnt = 0;

  task automatic check(string nm, logic [31:0] act, logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", nm, act, req);
    end
  endtask

  task automatic add_char(int r, int d, bit last);
    int v;
    v = (d & 255) | (last ? 256 : 0);
    sq[r].push_back(v);
    mq[r].push_back(v);
  endtask

  task automatic add_msg(int r, int len, bit with_last);
    for (int i = 0; i < len; i++)
      add_char(r, int'($urandom_range(0, 255)),
               with_last && (i == len - 1));
  endtask

  // Message-level reference: round-robin over non-empty queues,
  // each grant carries chars up to tlast or MB chars.
  task automatic model_run();
    while (1) begin
      int k;
      k = -1;
      for (int i = 0; i < N; i++) begin
        int c;
        c = (m_ptr + i) % N;
        if (k < 0 && mq[c].size() > 0) k = c;
      end
      if (k < 0) break;
      exp_gnt.push_back(1 << k);
      m_ptr = (k + 1) % N;
      for (int n = 0; n < MB; n++) begin
        int v;
        if (mq[k].size() == 0) break;
        v = mq[k].pop_front();
        exp_tx.push_back(v & 255);
        if (v >= 256) break;
      end
    end
  endtask

  // Driver: present queue fronts, pop on accepted handshakes.
  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        int v;
        v = (sq[k].size() > 0) ? sq[k][0] : 0;
        bus.req_tvalid_i[k]         = (sq[k].size() > 0);
        bus.req_tdata_i[k*W +: W]   = v[7:0];
        bus.req_tlast_i[k]          = v[8];
      end
      bus.tx_ready_i = ($urandom_range(0, 99) < ready_pct);
      #4;
      if (!rst) begin
        for (int k = 0; k < N; k++)
          if (bus.req_tvalid_i[k] && bus.req_tready_o[k])
            void'(sq[k].pop_front());
      end
    end
  end

  // Monitor: compare grants and sent chars against the scoreboard.
  initial begin
    logic [N-1:0] prev_g;
    logic [N-1:0] g;
    prev_g = '0;
    forever begin
      @(negedge clk);
      #4;
      if (rst) begin
        prev_g = '0;
      end else begin
        g = bus.grant_o;
        if (g != 0 && prev_g == 0) begin
          if (exp_gnt.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL grant_extra: got %0h, want none", g);
          end else begin
            check("grant", 32'(g), 32'(exp_gnt.pop_front()));
          end
        end
        prev_g = g;
        if (bus.tx_valid_o && bus.tx_ready_i) begin
          tx_cnt++;
          if (exp_tx.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL tx_extra: got %0h, want none",
                     bus.tx_data_o);
          end else begin
            check("tx_data", 32'(bus.tx_data_o),
                  32'(exp_tx.pop_front()));
          end
        end
        if (bus.tx_valid_o && !bus.tx_ready_i)
          check("tready_stall", 32'(bus.req_tready_o), 0);
        if (|bus.req_tready_o)
          check("tready_mask", 32'(bus.req_tready_o & ~g), 0);
      end
    end
  end

  task automatic wait_done(string nm, int budget, logic [N-1:0] fin);
    int c;
    int pend;
    c = 0;
    while ((exp_tx.size() > 0 || exp_gnt.size() > 0) && c < budget) begin
      @(negedge clk);
      c++;
    end
    if (c >= budget) begin
      n_chk++; n_fail++;
      $display("FAIL %s_timeout: got %0d left, want 0", nm,
               exp_tx.size());
    end
    repeat (6) @(negedge clk);
    #4;
    pend = 0;
    for (int k = 0; k < N; k++) pend += sq[k].size();
    check({nm, "_grant"}, 32'(bus.grant_o), 32'(fin));
    check({nm, "_txv"}, 32'(bus.tx_valid_o), 0);
    check({nm, "_active"}, 32'(bus.active_o), 32'(fin != 0));
    check({nm, "_pending"}, 32'(pend), 0);
  endtask

  task automatic check_zero(string nm);
    check({nm, "_grant"}, 32'(bus.grant_o), 0);
    check({nm, "_tready"}, 32'(bus.req_tready_o), 0);
    check({nm, "_txv"}, 32'(bus.tx_valid_o), 0);
    check({nm, "_txd"}, 32'(bus.tx_data_o), 0);
    check({nm, "_active"}, 32'(bus.active_o), 0);
  endtask

  task automatic reset_pulse(string nm);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_zero(nm);
    for (int k = 0; k < N; k++) begin
      sq[k].delete();
      mq[k].delete();
    end
    exp_tx.delete();
    exp_gnt.delete();
    m_ptr = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int c;
    bus.req_tvalid_i = '0;
    bus.req_tdata_i  = '0;
    bus.req_tlast_i  = '0;
    bus.tx_ready_i   = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // All four valid, one-char messages, req0 has two: 0,1,2,3,0.
    ready_pct = 100;
    add_char(0, 8'h10, 1'b1);
    add_char(0, 8'h11, 1'b1);
    add_char(1, 8'h20, 1'b1);
    add_char(2, 8'h30, 1'b1);
    add_char(3, 8'h40, 1'b1);
    model_run();
    wait_done("rr4", 400, '0);

    // Two-char message from req0 with the UART always ready.
    add_char(0, 8'h41, 1'b0);
    add_char(0, 8'h42, 1'b1);
    model_run();
    wait_done("req0", 200, '0);

    // UART stalls with a char held, then resumes.
    ready_pct = 0;
    add_msg(0, 6, 1'b1);
    model_run();
    repeat (10) @(negedge clk);
    #4;
    check("stall_txv", 32'(bus.tx_valid_o), 1);
    ready_pct = 100;
    wait_done("stall", 300, '0);

    // Random traffic: mixed lengths, some above MAX_BURST.
    for (int p = 0; p < 6; p++) begin
      bit any;
      ready_pct = int'($urandom_range(30, 100));
      any = 1'b0;
      for (int r = 0; r < N; r++) begin
        if ($urandom_range(0, 1) == 1 || (r == N - 1 && !any)) begin
          any = 1'b1;
          for (int m = 0; m < int'($urandom_range(1, 2)); m++)
            add_msg(r, int'($urandom_range(1, 20)), 1'b1);
        end
      end
      model_run();
      wait_done("rand", 4000, '0);
    end

    // Reset during the third char of an eight-char message.
    ready_pct = 100;
    add_msg(0, 8, 1'b1);
    model_run();
    t0 = tx_cnt;
    c = 0;
    while (tx_cnt < t0 + 2 && c < 100) begin
      @(negedge clk);
      c++;
    end
    check("mid_reached", 32'(tx_cnt >= t0 + 2), 1);
    reset_pulse("midrst");
    add_char(1, 8'h5a, 1'b1);
    add_char(3, 8'ha5, 1'b1);
    model_run();
    wait_done("postrst", 200, '0);

    // req2 streams 20 chars without tlast: 16, rearbitrate, 4.
    ready_pct = int'($urandom_range(50, 100));
    add_msg(2, 20, 1'b0);
    model_run();
    wait_done("burst", 600, 4'b0100);

    // req1 waits while req2 holds an idle grant.
`ifdef UART_TX_ARB_TIMEOUT_EN
    add_char(1, 8'h77, 1'b1);
    model_run();
    wait_done("timeout", 400, '0);
`else
    sq[1].push_back(8'h77 | 256);
    repeat (70) @(negedge clk);
    #4;
    check("hold_grant", 32'(bus.grant_o), 32'(4'b0100));
`endif
    reset_pulse("endrst");
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
